// File: rtl/adf4030_up_sequencer.sv
// Command-driven bus initiator for the ADF4030 up_* register port.
// Executes write, read, read-modify-write and poll-until-match commands, one response per command.
module adf4030_up_sequencer #(
    parameter int ACK_TIMEOUT = 256,
    parameter int POLL_MAX    = 1024,
    parameter int POLL_GAP    = 16
) (
    input  logic        up_clk,
    input  logic        up_rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic [31:0] cmd_mask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_status,
    output logic        busy,
    output logic        up_wreq,
    output logic [7:0]  up_waddr,
    output logic [31:0] up_wdata,
    input  logic        up_wack,
    output logic        up_rreq,
    output logic [7:0]  up_raddr,
    input  logic [31:0] up_rdata,
    input  logic        up_rack
);

    localparam int TW = $clog2(ACK_TIMEOUT) + 1;
    localparam int PW = $clog2(POLL_MAX) + 1;
    localparam int GW = $clog2(POLL_GAP) + 1;

    localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_MAX - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(POLL_GAP - 1);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_POLL  = 2'b10;
    localparam logic [1:0] OP_RMW   = 2'b11;

    localparam logic [1:0] ST_OK        = 2'b00;
    localparam logic [1:0] ST_TIMEOUT   = 2'b01;
    localparam logic [1:0] ST_EXHAUSTED = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        GAP,
        WR_REQ,
        WR_WAIT,
        RSP
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [7:0]      addr_q, addr_d;
    logic [31:0]     data_q, data_d;
    logic [31:0]     mask_q, mask_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [PW-1:0]   poll_cnt_q, poll_cnt_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [1:0]      status_q, status_d;
    logic            poll_match;

    always_ff @(posedge up_clk or posedge up_rst) begin
        if (up_rst) begin
            state_q    <= IDLE;
            op_q       <= 2'b00;
            addr_q     <= 8'h00;
            data_q     <= 32'h0;
            mask_q     <= 32'h0;
            timer_q    <= '0;
            poll_cnt_q <= '0;
            gap_cnt_q  <= '0;
            rdata_q    <= 32'h0;
            status_q   <= ST_OK;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            mask_q     <= mask_d;
            timer_q    <= timer_d;
            poll_cnt_q <= poll_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            rdata_q    <= rdata_d;
            status_q   <= status_d;
        end
    end

    assign poll_match = ((up_rdata & mask_q) == (data_q & mask_q));

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        data_d     = data_q;
        mask_d     = mask_q;
        timer_d    = timer_q;
        poll_cnt_d = poll_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        rdata_d    = rdata_q;
        status_d   = status_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d       = cmd_op;
                    addr_d     = cmd_addr;
                    data_d     = cmd_data;
                    mask_d     = cmd_mask;
                    poll_cnt_d = '0;
                    state_d    = (cmd_op == OP_WRITE) ? WR_REQ : RD_REQ;
                end
            end
            RD_REQ: begin
                timer_d = '0;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                // An ack in the expiry cycle still counts: ack is tested first.
                if (up_rack) begin
                    unique case (op_q)
                        OP_RMW: begin
                            data_d  = (up_rdata & ~mask_q) | (data_q & mask_q);
                            state_d = WR_REQ;
                        end
                        OP_POLL: begin
                            if (poll_match) begin
                                rdata_d  = up_rdata;
                                status_d = ST_OK;
                                state_d  = RSP;
                            end else if (poll_cnt_q == POLL_LAST) begin
                                rdata_d  = up_rdata;
                                status_d = ST_EXHAUSTED;
                                state_d  = RSP;
                            end else begin
                                poll_cnt_d = poll_cnt_q + PW'(1);
                                gap_cnt_d  = '0;
                                state_d    = GAP;
                            end
                        end
                        default: begin
                            rdata_d  = up_rdata;
                            status_d = ST_OK;
                            state_d  = RSP;
                        end
                    endcase
                end else if (timer_q == TIMER_LAST) begin
                    rdata_d  = 32'h0;
                    status_d = ST_TIMEOUT;
                    state_d  = RSP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = RD_REQ;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            WR_REQ: begin
                timer_d = '0;
                state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (up_wack) begin
                    rdata_d  = (op_q == OP_RMW) ? data_q : 32'h0;
                    status_d = ST_OK;
                    state_d  = RSP;
                end else if (timer_q == TIMER_LAST) begin
                    rdata_d  = 32'h0;
                    status_d = ST_TIMEOUT;
                    state_d  = RSP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign rsp_valid  = (state_q == RSP);
    assign rsp_rdata  = rdata_q;
    assign rsp_status = status_q;
    assign up_wreq    = (state_q == WR_REQ);
    assign up_rreq    = (state_q == RD_REQ);
    assign up_waddr   = addr_q;
    assign up_raddr   = addr_q;
    assign up_wdata   = data_q;

endmodule
